// File: rtl/mem_pkg.sv
// Shared types for the RAM arbiter: CPU command codes, arbiter FSM states, owner encoding.
// Pure declarations; no timing or flow control lives here.
package mem_pkg;

  typedef logic [1:0] mem_cmd_t;

  localparam mem_cmd_t MNONE  = 2'b00;
  localparam mem_cmd_t MREAD  = 2'b01;
  localparam mem_cmd_t MWRITE = 2'b10;

  typedef enum logic [1:0] {
    CPU_OWN   = 2'd0,
    DBG_ISSUE = 2'd1,
    DBG_DONE  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DBG = 1'b1
  } owner_t;

  // The unused encoding 2'b11 behaves exactly like an idle cycle.
  function automatic mem_cmd_t norm_cmd(input mem_cmd_t cmd);
    return (cmd == 2'b11) ? MNONE : cmd;
  endfunction

endpackage

// File: rtl/cpu_access_tracker.sv
// Remembers the last CPU access that reached the RAM and flags a fresh one.
// Zero-latency cpu_new; registers update only on cycles the CPU actually proceeds.
module cpu_access_tracker
  import mem_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  mem_cmd_t          cmd,
  input  logic [ADDR_W-1:0] addr,
  output logic              cpu_new
);

  mem_cmd_t          prev_cmd;
  logic [ADDR_W-1:0] prev_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_cmd  <= MNONE;
      prev_addr <= '0;
    end else if (load) begin
      prev_cmd  <= cmd;
      prev_addr <= addr;
    end
  end

  // A repeat of the previous command/address is the CPU's wait-state half.
  assign cpu_new = (cmd != MNONE) && ((cmd != prev_cmd) || (addr != prev_addr));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between the CPU (transparent, stalled when displaced) and a debug req/ack port.
// Debug ack 2 cycles after grant; CPU continuations are never preempted; round-robin on new accesses.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  mem_cmd_t          cpu_cmd,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  arb_state_t        state;
  owner_t            last_owner;
  logic [DATA_W-1:0] dbg_hold;
  mem_cmd_t          cmd_n;
  logic              cpu_busy;
  logic              cpu_new;
  logic              grant;
  logic              cpu_go;
  logic              dbg_drive;

  assign cmd_n     = norm_cmd(cpu_cmd);
  assign cpu_busy  = (cmd_n != MNONE);
  assign dbg_drive = (state == DBG_ISSUE);

  assign grant = (state == CPU_OWN) && dbg_req &&
                 (!cpu_busy || (cpu_new && (last_owner == OWNER_CPU)));

  assign cpu_stall = cpu_busy && (dbg_drive || grant);
  assign cpu_go    = !dbg_drive && !cpu_stall;

  cpu_access_tracker #(.ADDR_W(ADDR_W)) u_tracker (
    .clk     (clk),
    .reset   (reset),
    .load    (cpu_go),
    .cmd     (cmd_n),
    .addr    (cpu_addr),
    .cpu_new (cpu_new)
  );

  assign ram_addr  = dbg_drive ? dbg_addr  : cpu_addr;
  assign ram_din   = dbg_drive ? dbg_wdata : cpu_wdata;
  // Gated by reset so a held CPU write cannot corrupt RAM while in reset.
  assign ram_we    = reset && (dbg_drive ? dbg_we : (cmd_n == MWRITE));
  assign cpu_rdata = ram_dout;
  assign dbg_rdata = (state == DBG_DONE) ? ram_dout : dbg_hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= CPU_OWN;
      last_owner <= OWNER_CPU;
      dbg_hold   <= '0;
      dbg_ack    <= 1'b0;
    end else begin
      dbg_ack <= 1'b0;
      unique case (state)
        CPU_OWN: begin
          if (grant) begin
            state      <= DBG_ISSUE;
            last_owner <= OWNER_DBG;
          end else if (cpu_new && cpu_go) begin
            last_owner <= OWNER_CPU;
          end
        end
        DBG_ISSUE: begin
          state   <= DBG_DONE;
          dbg_ack <= 1'b1;
        end
        DBG_DONE: begin
          state <= CPU_OWN;
          if (!dbg_we) dbg_hold <= ram_dout;
          // The CPU gets the port back this cycle, so a fresh access here counts as its turn.
          if (cpu_new && cpu_go) last_owner <= OWNER_CPU;
        end
        default: state <= CPU_OWN;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then randomized CPU/debug traffic,
// checked cycle by cycle against a behavioural model with a shadow memory.
module tb_mem_arbiter;

  localparam int AW = 9;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    cpu_cmd;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_cmd   (cpu_cmd),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout)
  );

  // RAM with registered read of the old contents.
  logic [DW-1:0] ram [512];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  int            m_phase;     // 0 CPU has port, 1 debug access in flight, 2 debug completing
  bit            m_dbg_last;  // debug had the most recent turn
  logic [1:0]    m_pcmd;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_hold, m_issue_val, m_rd_val;
  bit            m_rd_pend;
  logic [DW-1:0] shadow [512];

  bit            obs_ack, obs_stall, obs_we;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_drd;

  task automatic model_reset();
    m_phase = 0; m_dbg_last = 0; m_pcmd = 2'b00; m_paddr = '0;
    m_hold = '0; m_rd_pend = 0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic [1:0]    c;
    bit            busy, fresh, grant, e_stall, e_we, go;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, e_drd;
    @(negedge clk);
    c       = (cpu_cmd == 2'b11) ? 2'b00 : cpu_cmd;
    busy    = (c != 2'b00);
    fresh   = busy && ((c != m_pcmd) || (cpu_addr != m_paddr));
    grant   = (m_phase == 0) && dbg_req && (!busy || (fresh && !m_dbg_last));
    e_stall = busy && ((m_phase == 1) || grant);
    e_we    = reset && ((m_phase == 1) ? dbg_we : (c == 2'b10));
    e_addr  = (m_phase == 1) ? dbg_addr  : cpu_addr;
    e_din   = (m_phase == 1) ? dbg_wdata : cpu_wdata;
    e_drd   = (m_phase == 2) ? m_issue_val : m_hold;
    chk("cpu_stall", cpu_stall, e_stall);
    chk("ram_we", ram_we, e_we);
    chk("ram_addr", ram_addr, e_addr);
    chk("ram_din", ram_din, e_din);
    chk("dbg_ack", dbg_ack, m_phase == 2);
    chk("dbg_rdata", dbg_rdata, e_drd);
    if (m_rd_pend) chk("cpu_rdata", cpu_rdata, m_rd_val);
    obs_ack = dbg_ack; obs_stall = cpu_stall; obs_we = ram_we;
    obs_addr = ram_addr; obs_drd = dbg_rdata;
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      go        = (m_phase != 1) && !e_stall;
      m_rd_pend = go && (c == 2'b01);
      if (m_rd_pend) m_rd_val = shadow[cpu_addr];
      if (m_phase == 1) m_issue_val = shadow[dbg_addr];
      if (e_we) shadow[e_addr] = e_din;
      if (m_phase == 2 && !dbg_we) m_hold = m_issue_val;
      if (go) begin m_pcmd = c; m_paddr = cpu_addr; end
      if (grant) m_dbg_last = 1;
      else if (go && fresh) m_dbg_last = 0;
      m_phase = grant ? 1 : ((m_phase == 1) ? 2 : 0);
    end
    #1;
  endtask

  // Holds a debug request until acked (bounded); reports latency, stalls seen and ack data.
  task automatic dbg_run(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int lat, output int stalls, output bit issue_we,
                         output logic [DW-1:0] drd);
    dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    lat = -1; stalls = 0; issue_we = 0; drd = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (obs_stall) stalls++;
      if (i == 1) issue_we = obs_we;
      if (obs_ack) begin lat = i; drd = obs_drd; break; end
    end
    dbg_req = 0;
    if (lat < 0) chk("dbg_timeout", obs_ack, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int            lat, stalls, ccnt, gap, acks, served, last_ack, min_gap, max_gap;
    bit            iwe;
    logic [DW-1:0] drd;

    for (int i = 0; i < 512; i++) begin
      ram[i] = DW'($urandom);
      shadow[i] = ram[i];
    end
    reset = 0; cpu_cmd = 2'b10; cpu_addr = 9'h033; cpu_wdata = 16'h1234;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    model_reset();

    // Reset with a CPU write held: no RAM write, no ack, zero read data.
    step();
    chk("rst_ram_we", obs_we, 1'b0);
    chk("rst_dbg_rdata", obs_drd, 16'h0);
    step();
    reset = 1; cpu_cmd = 2'b01; cpu_addr = 9'h1A5;
    step();
    chk("pass_addr", obs_addr, 9'h1A5);
    cpu_cmd = 2'b00;
    step();

    // Idle-CPU debug write then read back.
    dbg_run(1'b1, 9'h050, 16'hBEEF, lat, stalls, iwe, drd);
    chk("wr_latency", lat, 2);
    chk("wr_issue_we", iwe, 1'b1);
    step();
    dbg_run(1'b0, 9'h050, 16'h0000, lat, stalls, iwe, drd);
    chk("rd_latency", lat, 2);
    chk("rd_beef", drd, 16'hBEEF);
    step();
    chk("rd_hold_beef", obs_drd, 16'hBEEF);

    // Contention: give the CPU the last turn, then a new CPU read meets a debug read.
    cpu_cmd = 2'b01; cpu_addr = 9'h030; step();
    cpu_cmd = 2'b00; step();
    cpu_cmd = 2'b01; cpu_addr = 9'h010;
    dbg_run(1'b0, 9'h050, 16'h0000, lat, stalls, iwe, drd);
    chk("cont_stalls", stalls, 2);
    chk("cont_latency", lat, 2);
    cpu_cmd = 2'b00;
    step();
    chk("cont_cpu_rdata", cpu_rdata, shadow[9'h010]);

    // Atomicity: debug request during the wait-state half of a CPU read.
    cpu_cmd = 2'b01; cpu_addr = 9'h020; step();
    dbg_req = 1; dbg_we = 0; dbg_addr = 9'h050;
    step();
    chk("atom_stall", obs_stall, 1'b0);
    chk("atom_addr", obs_addr, 9'h020);
    cpu_cmd = 2'b00;
    dbg_run(1'b0, 9'h050, 16'h0000, lat, stalls, iwe, drd);
    chk("atom_latency", lat, 2);

    // Fairness: new CPU access every cycle against a continuous debug request.
    dbg_req = 1; dbg_we = 0; dbg_addr = 9'h007;
    cpu_cmd = 2'b01; cpu_addr = 9'h100;
    acks = 0; served = 0; last_ack = -1; min_gap = 1000; max_gap = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      step();
      if (!obs_stall) begin served++; cpu_addr = cpu_addr + 9'd1; end
      if (obs_ack) begin
        if (last_ack >= 0) begin
          if (cyc - last_ack < min_gap) min_gap = cyc - last_ack;
          if (cyc - last_ack > max_gap) max_gap = cyc - last_ack;
        end
        last_ack = cyc; acks++;
        dbg_addr = AW'($urandom_range(0, 31));
      end
    end
    dbg_req = 0; cpu_cmd = 2'b00;
    chk("fair_min_gap", min_gap, 3);
    chk("fair_max_gap", max_gap, 3);
    chk("fair_dbg_served", acks >= 12, 1'b1);
    chk("fair_cpu_served", served >= 12, 1'b1);
    step();

    // Reset while the debug access is in flight.
    dbg_req = 1; dbg_we = 0; dbg_addr = 9'h050;
    step();
    reset = 0; dbg_req = 0;
    model_reset();
    step();
    chk("rstmid_ack", obs_ack, 1'b0);
    reset = 1;
    step();
    chk("rstmid_ack_after", obs_ack, 1'b0);
    cpu_cmd = 2'b01; cpu_addr = 9'h044;
    step();
    chk("rstmid_stall", obs_stall, 1'b0);
    chk("rstmid_addr", obs_addr, 9'h044);

    // Randomized traffic on a small address window to force collisions.
    ccnt = 0; gap = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      step();
      if (!obs_stall) begin
        if (ccnt > 0) ccnt--;
        else begin
          cpu_cmd   = 2'($urandom_range(0, 3));
          cpu_addr  = AW'($urandom_range(0, 15));
          cpu_wdata = DW'($urandom);
          ccnt      = $urandom_range(0, 1);
        end
      end
      if (dbg_req) begin
        if (obs_ack) begin dbg_req = 0; gap = $urandom_range(0, 3); end
      end else if (gap > 0) begin
        gap--;
      end else begin
        dbg_req   = 1;
        dbg_we    = 1'($urandom_range(0, 1));
        dbg_addr  = AW'($urandom_range(0, 15));
        dbg_wdata = DW'($urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
